scan_chain_ctrl: RTL and testbench

Sequencer for a serial chain of clearable D flip-flops. It shifts a parallel word into the chain one bit per cycle, LSB first. In the same pass it captures the bits that fall out of the chain end, pulses an update strobe, and returns the captured word over a valid/ready handshake. It sits between a register-programming master and a bank of chained DFF cells, so that a chain of any length is loaded and read back through one serial pin pair.

---
 rtl/scan_chain_ctrl_pkg.sv | 28 ++
 rtl/scan_chain_ctrl_bit_counter.sv | 27 ++
 rtl/scan_chain_ctrl.sv | 99 +++++++++
 tb/tb_scan_chain_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and helpers for the scan chain controller.
// SCAN_PARITY_EN appends an even-parity bit to every shifted word.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

`ifdef SCAN_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Number of bits shifted per operation for a given data width.
  function automatic int shift_count(input int chain_len);
    return chain_len + PARITY_BITS;
  endfunction

  // Callers zero-extend narrower words; extra zeros do not change the result.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_bit_counter.sv
// Up-counter with synchronous load-zero that saturates at LIMIT and flags it.
module scan_bit_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 7
) (
  input  logic clock,
  input  logic clear,
  input  logic load_zero,
  input  logic enable,
  output logic at_limit
);

  logic [WIDTH-1:0] count;

  assign at_limit = (count == WIDTH'(LIMIT));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Loads a word into an external DFF chain LSB first while capturing the old contents.
// SCAN_PARITY_EN adds a parity cell to the chain and a parity_err output.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter  int CHAIN_LEN = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic                 scan_out,
  input  logic                 scan_in,
  output logic                 shift_en,
  output logic                 update_pulse,
  output logic [CHAIN_LEN-1:0] cap_data,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic                 busy
`ifdef SCAN_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int SHIFT_LEN = shift_count(CHAIN_LEN);

  state_t               state, state_next;
  logic [SHIFT_LEN-1:0] sreg;
  logic [SHIFT_LEN-1:0] load_word;
  logic                 start_fire;
  logic                 last_shift;

  assign start_fire = start_valid && (state == IDLE);

`ifdef SCAN_PARITY_EN
  assign load_word = {even_parity(64'(load_data)), load_data};
`else
  assign load_word = load_data;
`endif

  scan_bit_counter #(
    .WIDTH(CNT_W),
    .LIMIT(SHIFT_LEN - 1)
  ) u_bit_counter (
    .clock    (clock),
    .clear    (clear),
    .load_zero(start_fire),
    .enable   (state == SHIFT),
    .at_limit (last_shift)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_fire) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = UPDATE;
      UPDATE:  state_next = DONE;
      DONE:    if (done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured bits enter at the MSB so the first one out of the chain ends up at bit 0.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sreg <= '0;
    end else if (start_fire) begin
      sreg <= load_word;
    end else if (state == SHIFT) begin
      sreg <= {scan_in, sreg[SHIFT_LEN-1:1]};
    end
  end

  always_comb begin
    start_ready  = (state == IDLE);
    shift_en     = (state == SHIFT);
    update_pulse = (state == UPDATE);
    done_valid   = (state == DONE);
    busy         = (state != IDLE);
    scan_out     = (state == SHIFT) && sreg[0];
    cap_data     = sreg[CHAIN_LEN-1:0];
`ifdef SCAN_PARITY_EN
    parity_err   = (state == DONE) &&
                   (sreg[CHAIN_LEN] != even_parity(64'(sreg[CHAIN_LEN-1:0])));
`endif
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench with loopback DFF-chain models and a scoreboard of expected captures.
// Builds with or without SCAN_PARITY_EN.
module tb_scan_chain_ctrl;
  import scan_ctrl_pkg::*;

  localparam int CL  = 8;
  localparam int SL  = shift_count(CL);
  localparam int CL2 = 2;
  localparam int SL2 = shift_count(CL2);

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  logic          start_valid = 1'b0, start_ready, scan_out, scan_in, shift_en;
  logic          update_pulse, done_valid, done_ready = 1'b0, busy;
  logic [CL-1:0] load_data = '0, cap_data;
  logic          sv2 = 1'b0, sr2, so2, si2, se2, up2, dv2, dr2 = 1'b0, busy2;
  logic [CL2-1:0] ld2 = '0, cap2;
`ifdef SCAN_PARITY_EN
  logic          parity_err, pe2;
`endif

  // External chains: cell 0 is the head, the last cell feeds scan_in.
  logic [SL-1:0]  chain  = '0;
  logic [SL2-1:0] chain2 = '1;
  logic           flip   = 1'b0;
  assign scan_in = chain[SL-1] ^ flip;
  assign si2     = chain2[SL2-1];
  always @(posedge clock) if (shift_en) chain  <= {chain[SL-2:0], scan_out};
  always @(posedge clock) if (se2)      chain2 <= {chain2[SL2-2:0], so2};

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  scan_chain_ctrl #(.CHAIN_LEN(CL)) u_dut (
    .clock(clock), .clear(clear), .start_valid(start_valid), .start_ready(start_ready),
    .load_data(load_data), .scan_out(scan_out), .scan_in(scan_in), .shift_en(shift_en),
    .update_pulse(update_pulse), .cap_data(cap_data), .done_valid(done_valid),
    .done_ready(done_ready), .busy(busy)
`ifdef SCAN_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  scan_chain_ctrl #(.CHAIN_LEN(CL2)) u_dut2 (
    .clock(clock), .clear(clear), .start_valid(sv2), .start_ready(sr2),
    .load_data(ld2), .scan_out(so2), .scan_in(si2), .shift_en(se2),
    .update_pulse(up2), .cap_data(cap2), .done_valid(dv2),
    .done_ready(dr2), .busy(busy2)
`ifdef SCAN_PARITY_EN
    , .parity_err(pe2)
`endif
  );

  int tests = 0;
  int fails = 0;
  logic [CL-1:0] exp_q[$];
  logic [CL-1:0] prev_load = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full operation; stall>0 holds done_ready low that many cycles, flip_k>=0 corrupts one captured bit.
  task automatic do_op(input logic [CL-1:0] word, input int stall, input int flip_k);
    logic [SL-1:0] seen, exp_bits;
    logic [CL-1:0] exp_cap, cap_hold;
    logic          acc, stable;
    int            n_shift, n_upd;
    start_valid = 1'b1;
    load_data   = word;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = start_ready;
      tick();
    end
    start_valid = 1'b0;
    load_data   = CL'($urandom);
    check("start_accept", 32'(acc), 1);
    exp_q.push_back(prev_load);
    prev_load = word;
    seen = '0; n_shift = 0; n_upd = 0;
    for (int i = 0; i < 100 && !done_valid; i++) begin
      if (shift_en) begin
        if (n_shift < SL) seen[n_shift] = scan_out;
        flip = (n_shift == flip_k);
        n_shift++;
      end
      if (update_pulse) n_upd++;
      tick();
      flip = 1'b0;
    end
`ifdef SCAN_PARITY_EN
    exp_bits = {^word, word};
`else
    exp_bits = word;
`endif
    check("shift_cycles", n_shift, SL);
    check("scan_out_seq", 32'(seen), 32'(exp_bits));
    check("update_pulses", n_upd, 1);
    check("done_valid", 32'(done_valid), 1);
    check("sb_nonempty", 32'(exp_q.size() > 0), 1);
    exp_cap = exp_q.pop_front();
    if (flip_k >= 0 && flip_k < CL) exp_cap[flip_k] = ~exp_cap[flip_k];
    check("cap_data", 32'(cap_data), 32'(exp_cap));
`ifdef SCAN_PARITY_EN
    check("parity_err", 32'(parity_err), 32'(flip_k >= 0));
`endif
    if (stall > 0) begin
      cap_hold    = cap_data;
      stable      = 1'b1;
      start_valid = 1'b1;
      load_data   = CL'($urandom);
      for (int i = 0; i < stall; i++) begin
        tick();
        stable &= done_valid && (cap_data == cap_hold) && !start_ready && busy;
      end
      check("stall_stable", 32'(stable), 1);
      start_valid = 1'b0;
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("done_release", 32'(done_valid), 0);
    check("idle_ready", 32'(start_ready), 1);
  endtask

  initial begin
    logic         acc2, will, prev_se;
    logic [SL2-1:0] seen2;
    int           n2, accepts, dones, nsh;
    int           rise_q[$];

    // Reset held with random traffic on the inputs
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'($urandom); done_ready = 1'($urandom); load_data = CL'($urandom);
      sv2 = 1'($urandom); ld2 = CL2'($urandom);
      tick();
    end
    check("rst_start_ready", 32'(start_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_shift_en", 32'(shift_en), 0);
    check("rst_done_valid", 32'(done_valid), 0);
    check("rst_cap_data", 32'(cap_data), 0);
    check("rst_update", 32'(update_pulse), 0);
    check("rst_scan_out", 32'(scan_out), 0);
    start_valid = 1'b0; done_ready = 1'b0; sv2 = 1'b0;
    clear = 1'b1;
    tick();

    do_op(8'hA5, 0, -1);
    do_op(8'h3C, 20, -1);
    do_op(8'h81, 0, 3);
    do_op(8'h07, 0, -1);
    do_op(8'h00, 0, -1);
    do_op(8'h5E, 0, 6);

    // Back-to-back with both handshakes held high
    start_valid = 1'b1; done_ready = 1'b1; load_data = 8'h5A;
    accepts = 0; dones = 0; nsh = 0; prev_se = 1'b0;
    for (int i = 0; i < 200 && dones < 3; i++) begin
      will = start_valid && start_ready;
      if (will) begin
        exp_q.push_back(prev_load);
        prev_load = load_data;
        accepts++;
      end
      if (done_valid) begin
        check("b2b_sb_nonempty", 32'(exp_q.size() > 0), 1);
        check("b2b_cap", 32'(cap_data), 32'(exp_q.pop_front()));
        dones++;
      end
      if (shift_en && !prev_se) rise_q.push_back(cyc);
      if (shift_en) nsh++;
      prev_se = shift_en;
      tick();
      if (will && accepts == 3) start_valid = 1'b0;
    end
    start_valid = 1'b0; done_ready = 1'b0;
    check("b2b_ops", dones, 3);
    check("b2b_shifts", nsh, 3 * SL);
    check("b2b_rises", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check("b2b_period1", rise_q[1] - rise_q[0], SL + 3);
      check("b2b_period2", rise_q[2] - rise_q[1], SL + 3);
    end

    // Two-cell chain preloaded with ones
    sv2 = 1'b1; ld2 = 2'b10; acc2 = 1'b0;
    for (int i = 0; i < 50 && !acc2; i++) begin
      acc2 = sr2;
      tick();
    end
    sv2 = 1'b0;
    check("c2_accept", 32'(acc2), 1);
    n2 = 0; seen2 = '0;
    for (int i = 0; i < 50 && !dv2; i++) begin
      if (se2) begin
        if (n2 < SL2) seen2[n2] = so2;
        n2++;
      end
      tick();
    end
    check("c2_shift_cycles", n2, SL2);
    check("c2_scan_out_seq", 32'(seen2[CL2-1:0]), 32'(2'b10));
    check("c2_cap_data", 32'(cap2), 32'(2'b11));
    dr2 = 1'b1;
    tick();
    dr2 = 1'b0;
    check("c2_release", 32'(dv2), 0);

    // Asynchronous clear in the middle of a shift
    start_valid = 1'b1; load_data = 8'hFF; acc2 = 1'b0;
    for (int i = 0; i < 50 && !acc2; i++) begin
      acc2 = start_ready;
      tick();
    end
    start_valid = 1'b0;
    tick();
    tick();
    check("mid_shift_en", 32'(shift_en), 1);
    #2;
    clear = 1'b0;
    #1;
    check("clr_shift_en", 32'(shift_en), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_start_ready", 32'(start_ready), 1);
    check("clr_scan_out", 32'(scan_out), 0);
    tick();
    clear = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
